// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control FSM for the CPU datapath. It fetches an instruction
//   word from instruction memory and latches it. It then drives the
//   register-file selects, the register-file write strobe and the ALU op.
//   Finally it advances the program counter. One instruction takes
//   FETCH(1+N wait) -> DECODE -> EXECUTE -> WRITEBACK.
//   A HALT word leaves EXECUTE for HALTED without advancing the PC.
//
// Parameters
//   ADDR_WIDTH  width of program_counter / imem_addr
//   START_ADDR  PC loaded by reset and by an accepted start
//   PC_STEP     PC increment per retired instruction (wraps modulo 2^ADDR_WIDTH)
//
// Ports
//   clock, reset           single rising-edge clock, synchronous active-low reset
//   start                  begin execution at START_ADDR (accepted in IDLE/HALTED)
//   imem_req/imem_addr     fetch request (held until ack) and fetch address
//   imem_ack/imem_rdata    fetch data valid strobe and instruction word
//   instruction            latched instruction word
//   rf_read_sel_1/2        register-file read selects  (instr[20:16], [15:11])
//   rf_write_sel, rf_wen   register-file write select  (instr[25:21]) and strobe
//   alu_op                 ALU operation (instr[3:0])
//   program_counter        current PC
//   busy, halted           status: executing / stopped on HALT
//   illegal_seen           sticky: an illegal opcode has retired
//
// Optional feature (macro CPU_SEQ_PERF_EN)
//   Adds cycle_count (busy cycles) and retired_count (WRITEBACK exits + HALT).
//   Both are saturating 32-bit counters, cleared by reset and by accepted start.
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic [4:0]            rf_read_sel_1,
  output logic [4:0]            rf_read_sel_2,
  output logic [4:0]            rf_write_sel,
  output logic                  rf_wen,
  output logic [3:0]            alu_op,
  output logic [ADDR_WIDTH-1:0] program_counter,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal_seen
`ifdef CPU_SEQ_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           retired_count
`endif
);

  localparam logic [5:0] OPC_ALU  = 6'h00;
  localparam logic [5:0] OPC_HALT = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALTED
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [31:0]             instr_reg, instr_next;
  logic                    illegal_reg, illegal_next;

  logic [5:0]              opcode;

  assign opcode = instr_reg[31:26];

  // ---------------------------------------------------------------------------
  // State register. Reset wins over everything, including an ack that
  // arrives in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= START_ADDR;
      instr_reg   <= '0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      illegal_reg <= illegal_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    illegal_next = illegal_reg;
    imem_req     = 1'b0;
    rf_wen       = 1'b0;

    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_next      = START_ADDR;
          illegal_next = 1'b0;
          state_next   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_next = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        // HALT leaves the PC pointing at the HALT word itself.
        state_next = (opcode == OPC_HALT) ? ST_HALTED : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        // Writes to r0 are suppressed; illegal opcodes retire as NOPs.
        rf_wen = (opcode == OPC_ALU) && (instr_reg[25:21] != 5'd0);
        if (opcode != OPC_ALU) begin
          illegal_next = 1'b1;
        end
        pc_next    = pc_reg + PC_STEP;
        state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign imem_addr       = pc_reg;
  assign program_counter = pc_reg;
  assign instruction     = instr_reg;
  assign rf_read_sel_1   = instr_reg[20:16];
  assign rf_read_sel_2   = instr_reg[15:11];
  assign rf_write_sel    = instr_reg[25:21];
  assign alu_op          = instr_reg[3:0];
  assign busy            = (state_reg == ST_FETCH)   || (state_reg == ST_DECODE) ||
                           (state_reg == ST_EXECUTE) || (state_reg == ST_WRITEBACK);
  assign halted          = (state_reg == ST_HALTED);
  assign illegal_seen    = illegal_reg;

`ifdef CPU_SEQ_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters: index 0 counts busy cycles, index 1 counts retires.
  // ---------------------------------------------------------------------------
  logic        start_accept;
  logic [1:0]  cnt_inc;
  logic [31:0] cnt_reg [2];

  assign start_accept = start && ((state_reg == ST_IDLE) || (state_reg == ST_HALTED));
  assign cnt_inc[0]   = busy;
  assign cnt_inc[1]   = (state_reg == ST_WRITEBACK) ||
                        ((state_reg == ST_EXECUTE) && (opcode == OPC_HALT));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf_cnt
      always_ff @(posedge clock) begin
        if (!reset || start_accept) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && (cnt_reg[gi] != 32'hFFFF_FFFF)) begin
          cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign cycle_count   = cnt_reg[0];
  assign retired_count = cnt_reg[1];
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam logic [31:0] W_ALU0 = 32'h0062_0800;   // rd=3 rs1=2 rs2=1 op=0
  localparam logic [31:0] W_HALT = 32'hFC00_0000;
  localparam logic [31:0] W_ILL  = 32'h0400_0000;   // opcode 01
  localparam logic [31:0] W_RD0  = 32'h001F_0805;   // ALU, rd=0

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [4:0]  rf_read_sel_1, rf_read_sel_2, rf_write_sel;
  logic        rf_wen;
  logic [3:0]  alu_op;
  logic [31:0] program_counter;
  logic        busy, halted, illegal_seen;

  // narrow-address instance used for the wrap-around check
  logic        w_start, w_req, w_ack, w_wen, w_busy, w_halted, w_ill;
  logic [3:0]  w_addr, w_pc, w_op;
  logic [31:0] w_rdata, w_instr;
  logic [4:0]  w_rs1, w_rs2, w_rd;

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cycle_count, retired_count, w_cycle, w_retired;
`endif

  cpu_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .rf_read_sel_1(rf_read_sel_1), .rf_read_sel_2(rf_read_sel_2),
    .rf_write_sel(rf_write_sel), .rf_wen(rf_wen), .alu_op(alu_op),
    .program_counter(program_counter), .busy(busy), .halted(halted), .illegal_seen(illegal_seen)
`ifdef CPU_SEQ_PERF_EN
    , .cycle_count(cycle_count), .retired_count(retired_count)
`endif
  );

  cpu_sequencer #(.ADDR_WIDTH(4), .START_ADDR(4'd12), .PC_STEP(4'd4)) dut_w (
    .clock(clock), .reset(reset), .start(w_start),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .instruction(w_instr), .rf_read_sel_1(w_rs1), .rf_read_sel_2(w_rs2),
    .rf_write_sel(w_rd), .rf_wen(w_wen), .alu_op(w_op),
    .program_counter(w_pc), .busy(w_busy), .halted(w_halted), .illegal_seen(w_ill)
`ifdef CPU_SEQ_PERF_EN
    , .cycle_count(w_cycle), .retired_count(w_retired)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  // Scoreboard of expected register-file write strobes
  typedef struct {
    int         cyc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] op;
  } wen_t;
  wen_t sb[$];

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (rf_wen === 1'b1) begin
        if (sb.size() == 0) begin
          check_value("rf_wen_unexpected", 32'd1, 32'd0);
        end else begin
          wen_t e;
          e = sb.pop_front();
          check_value("wen_cycle", cyc, e.cyc);
          check_value("wen_rd", {27'd0, rf_write_sel}, {27'd0, e.rd});
          check_value("wen_rs1", {27'd0, rf_read_sel_1}, {27'd0, e.rs1});
          check_value("wen_rs2", {27'd0, rf_read_sel_2}, {27'd0, e.rs2});
          check_value("wen_op", {28'd0, alu_op}, {28'd0, e.op});
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        void'(sb.pop_front());
        check_value("wen_missing", 32'd0, 32'd1);
      end
    end
  end

  logic [31:0] exp_pc;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    exp_pc = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Serve one fetch with wait_n wait cycles; slot afterwards is DECODE.
  task automatic fetch(input logic [31:0] w, input int wait_n);
    int   n;
    wen_t e;
    n = 0;
    while (imem_req !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    check_value("fetch_req", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < wait_n; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      check_value("wait_req", {31'd0, imem_req}, 32'd1);
      check_value("wait_addr", imem_addr, exp_pc);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    check_value("fetch_addr", imem_addr, exp_pc);
    if (w[31:26] == 6'h00 && w[25:21] != 5'd0) begin
      e.cyc = cyc + 3;
      e.rd  = w[25:21];
      e.rs1 = w[20:16];
      e.rs2 = w[15:11];
      e.op  = w[3:0];
      sb.push_back(e);
    end
    step();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check_value("latched", instruction, w);
    check_value("decode_wen", {31'd0, rf_wen}, 32'd0);
    if (w[31:26] != 6'h3F) exp_pc = exp_pc + 32'd4;
  endtask

  task automatic wait_halt(input logic [31:0] pc);
    step();
    step();
    check_value("halted", {31'd0, halted}, 32'd1);
    check_value("halt_busy", {31'd0, busy}, 32'd0);
    check_value("halt_req", {31'd0, imem_req}, 32'd0);
    check_value("halt_pc", program_counter, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1;
    w1 = {6'h00, 5'd5, 5'd7, 5'd9, 7'd0, 4'hA};

    // 1. reset held with start and ack asserted
    reset = 1'b0; start = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    w_start = 1'b0; w_ack = 1'b0; w_rdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("rst_req", {31'd0, imem_req}, 32'd0);
      check_value("rst_busy", {31'd0, busy}, 32'd0);
      check_value("rst_halted", {31'd0, halted}, 32'd0);
      check_value("rst_illegal", {31'd0, illegal_seen}, 32'd0);
      check_value("rst_instr", instruction, 32'd0);
      check_value("rst_pc", program_counter, 32'd0);
    end
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0;
    step();
    check_value("idle_req", {31'd0, imem_req}, 32'd0);

    // 2 + 4. zero-wait ALU then HALT
    do_start();
    check_value("start_busy", {31'd0, busy}, 32'd1);
    fetch(W_ALU0, 0);
    check_value("sel1", {27'd0, rf_read_sel_1}, 32'd2);
    check_value("sel2", {27'd0, rf_read_sel_2}, 32'd1);
    check_value("wsel", {27'd0, rf_write_sel}, 32'd3);
    fetch(W_HALT, 0);
    wait_halt(32'd4);

    // 3 + 5. delayed ack, ignored start while busy, illegal, rd=0, HALT
    do_start();
    check_value("restart_halted", {31'd0, halted}, 32'd0);
    check_value("restart_pc", program_counter, 32'd0);
    fetch(w1, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    check_value("busy_start_ign", {31'd0, busy}, 32'd1);
    fetch(W_ILL, 0);
    step(); step(); step();
    check_value("illegal_seen", {31'd0, illegal_seen}, 32'd1);
    check_value("illegal_pc", program_counter, 32'd8);
    fetch(W_RD0, 0);
    fetch(W_HALT, 0);
    wait_halt(32'd12);
    check_value("illegal_sticky", {31'd0, illegal_seen}, 32'd1);
    do_start();
    check_value("start_clr_illegal", {31'd0, illegal_seen}, 32'd0);

    // 6a. reset during FETCH with a same-cycle ack
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = W_ALU0;
    step();
    reset = 1'b1; imem_ack = 1'b0;
    check_value("midrst_instr", instruction, 32'd0);
    check_value("midrst_busy", {31'd0, busy}, 32'd0);
    check_value("midrst_req", {31'd0, imem_req}, 32'd0);
    check_value("midrst_pc", program_counter, 32'd0);

    // 6b. 4-bit PC wraps 12 -> 0 -> 4
    w_start = 1'b1;
    step();
    w_start = 1'b0; w_ack = 1'b1; w_rdata = 32'd0;
    check_value("wrap_start", {28'd0, w_addr}, 32'd12);
    repeat (4) step();
    check_value("wrap_pc0", {28'd0, w_addr}, 32'd0);
    repeat (4) step();
    check_value("wrap_pc4", {28'd0, w_addr}, 32'd4);
`ifdef CPU_SEQ_PERF_EN
    check_value("perf_cycles", w_cycle, 32'd8);
    check_value("perf_retired", w_retired, 32'd2);
`endif
    w_ack = 1'b0;
    step();

    check_value("sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
